mem_arbiter: RTL

- Shares the single ternary memory port between two requesters: port A (CPU, instruction fetch and data load/store) and port B (program loader / debug).
- Sits between the CPU memory interface and the memory model, arbitrates round-robin, and sequences each access through a small FSM.
- Memory has a fixed 1-cycle read latency. All data and address buses use 2 bits per trit.

---
 rtl/mem_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one ternary memory port between port A (CPU) and port B (loader/debug).
// Optional per-port stall counters are enabled with `define MEM_ARB_STALL_CNT_EN.
module mem_arbiter #(
    parameter int WORD_SIZE     = 9,
    parameter int MEM_ADDR_SIZE = 9
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       a_req,
    input  logic                       a_write,
    input  logic [2*MEM_ADDR_SIZE-1:0] a_address,
    input  logic [2*WORD_SIZE-1:0]     a_write_data,
    output logic                       a_gnt,
    output logic                       a_rvalid,
    output logic [2*WORD_SIZE-1:0]     a_read_data,
    input  logic                       b_req,
    input  logic                       b_write,
    input  logic [2*MEM_ADDR_SIZE-1:0] b_address,
    input  logic [2*WORD_SIZE-1:0]     b_write_data,
    output logic                       b_gnt,
    output logic                       b_rvalid,
    output logic [2*WORD_SIZE-1:0]     b_read_data,
    output logic [2*MEM_ADDR_SIZE-1:0] mem_address,
    output logic [2*WORD_SIZE-1:0]     mem_write_data,
    output logic                       mem_read,
    output logic                       mem_write,
    input  logic [2*WORD_SIZE-1:0]     mem_read_data,
    output logic                       busy
`ifdef MEM_ARB_STALL_CNT_EN
    ,
    output logic [15:0]                a_stall_cnt,
    output logic [15:0]                b_stall_cnt
`endif
);

    localparam logic [1:0] TRIT_ZERO = 2'b00;
    localparam logic [2*WORD_SIZE-1:0]     WORD_ZERO = {WORD_SIZE{TRIT_ZERO}};
    localparam logic [2*MEM_ADDR_SIZE-1:0] ADDR_ZERO = {MEM_ADDR_SIZE{TRIT_ZERO}};

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t                     state, state_next;
    logic                       last_b;
    logic                       sel_b;
    logic                       pick_b;
    logic                       cmd_write;
    logic [2*MEM_ADDR_SIZE-1:0] cmd_address;
    logic [2*WORD_SIZE-1:0]     cmd_write_data;
    logic [2*WORD_SIZE-1:0]     a_rd_q, b_rd_q;
    logic                       issue, resp;

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            last_b         <= 1'b1;
            sel_b          <= 1'b0;
            cmd_write      <= 1'b0;
            cmd_address    <= ADDR_ZERO;
            cmd_write_data <= WORD_ZERO;
            a_rd_q         <= WORD_ZERO;
            b_rd_q         <= WORD_ZERO;
        end else begin
            state <= state_next;
            if (state == IDLE && (a_req || b_req)) begin
                sel_b          <= pick_b;
                cmd_write      <= pick_b ? b_write      : a_write;
                cmd_address    <= pick_b ? b_address    : a_address;
                cmd_write_data <= pick_b ? b_write_data : a_write_data;
            end
            if (state == ISSUE)
                last_b <= sel_b;
            if (state == RESP) begin
                if (sel_b)
                    b_rd_q <= mem_read_data;
                else
                    a_rd_q <= mem_read_data;
            end
        end
    end

    always_comb begin
        state_next = state;
        pick_b     = b_req && (!a_req || !last_b);
        case (state)
            IDLE:    if (a_req || b_req) state_next = ISSUE;
            ISSUE:   state_next = cmd_write ? IDLE : RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strobes are masked by reset so an aborted ISSUE/RESP cycle emits no grant or response.
    assign issue = (state == ISSUE) && !reset;
    assign resp  = (state == RESP)  && !reset;

    assign a_gnt    = issue && !sel_b;
    assign b_gnt    = issue &&  sel_b;
    assign a_rvalid = resp  && !sel_b;
    assign b_rvalid = resp  &&  sel_b;

    // The response cycle forwards memory data so read_data is valid alongside rvalid, then holds.
    assign a_read_data = a_rvalid ? mem_read_data : a_rd_q;
    assign b_read_data = b_rvalid ? mem_read_data : b_rd_q;

    assign mem_address    = cmd_address;
    assign mem_write_data = cmd_write_data;
    assign mem_read       = issue && !cmd_write;
    assign mem_write      = issue &&  cmd_write;
    assign busy           = (state != IDLE) && !reset;

`ifdef MEM_ARB_STALL_CNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            a_stall_cnt <= '0;
            b_stall_cnt <= '0;
        end else begin
            if (a_req && !a_gnt && a_stall_cnt != 16'hFFFF)
                a_stall_cnt <= a_stall_cnt + 16'd1;
            if (b_req && !b_gnt && b_stall_cnt != 16'hFFFF)
                b_stall_cnt <= b_stall_cnt + 16'd1;
        end
    end
`endif

endmodule
